// File: rtl/pll_lock_supervisor_pkg.sv
// ----------------------------------------------------------------------------
// pll_sup_pkg
//   Shared types and constants for the PLL lock supervisor.
//   - state_e : supervisor FSM states
//   - LOSS_W  : width of the lock-loss counter
//   - sat_inc : saturating increment for the lock-loss counter
// ----------------------------------------------------------------------------
package pll_sup_pkg;

    localparam int LOSS_W = 8;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == '1) ? v : v + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// ----------------------------------------------------------------------------
// pll_sup_if
//   Signal bundle between the supervisor and the PLL / board side.
//   pll_locked  PLL locked (asynchronous to clk)
//   restart     one-cycle request for a full re-lock sequence
//   pll_rst     PLL reset, active high
//   sys_rst_n   system reset, active low
//   lock_ok     high only while running
//   fault       high only in the latched fault state
//   loss_count  saturating count of lock losses seen while running
//   Modports: master = supervisor, slave = PLL/board side.
// ----------------------------------------------------------------------------
interface pll_sup_if;
    import pll_sup_pkg::*;

    logic              pll_locked;
    logic              restart;
    logic              pll_rst;
    logic              sys_rst_n;
    logic              lock_ok;
    logic              fault;
    logic [LOSS_W-1:0] loss_count;

    modport master (
        input  pll_locked,
        input  restart,
        output pll_rst,
        output sys_rst_n,
        output lock_ok,
        output fault,
        output loss_count
    );

    modport slave (
        output pll_locked,
        output restart,
        input  pll_rst,
        input  sys_rst_n,
        input  lock_ok,
        input  fault,
        input  loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a single asynchronous level.
//   clk    destination clock
//   rst_n  asynchronous active-low reset (output resets to 0)
//   i_d    asynchronous input
//   o_q    synchronised output, two cycles of latency
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// pll_lock_supervisor
//   Drives the PLL reset and watches its lock output. The system reset is only
//   released after lock has been held for STABLE_CYCLES; lock loss or a lock
//   timeout re-resets the PLL, and MAX_RETRIES consecutive timeouts latch a
//   fault until restart or rst_n.
//   clk    free-running reference clock (only clock)
//   rst_n  asynchronous active-low reset
//   bus    pll_sup_if.master: pll_locked/restart in; pll_rst, sys_rst_n,
//          lock_ok, fault, loss_count out (all registered)
// ----------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    pll_sup_if.master bus
);
    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    localparam logic [2:0] S_RESET_PLL = 3'(RESET_PLL);
    localparam logic [2:0] S_WAIT_LOCK = 3'(WAIT_LOCK);
    localparam logic [2:0] S_STABLE    = 3'(STABLE);
    localparam logic [2:0] S_RUN       = 3'(RUN);
    localparam logic [2:0] S_FAULT     = 3'(FAULT);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_MAX      = RET_W'(MAX_RETRIES);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_timer;
    logic [RET_W-1:0]  r_retries;
    logic [LOSS_W-1:0] r_loss;
    logic              r_pll_rst;
    logic              r_sys_rst_n;
    logic              r_lock_ok;
    logic              r_fault;

    logic [2:0]        w_state_next;
    logic [CNT_W-1:0]  w_timer_next;
    logic [CNT_W-1:0]  w_timer_inc;
    logic [RET_W-1:0]  w_retries_next;
    logic [RET_W-1:0]  w_retries_inc;
    logic [LOSS_W-1:0] w_loss_next;
    logic              w_locked_s;

    // pll_locked is only ever observed through this synchroniser.
    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.pll_locked),
        .o_q   (w_locked_s)
    );

    // Timer holds at all-ones (only reachable in RUN/FAULT) rather than wrapping.
    assign w_timer_inc   = (r_timer == '1) ? r_timer : r_timer + CNT_W'(1);
    assign w_retries_inc = r_retries + RET_W'(1);

    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = w_timer_inc;
        w_retries_next = r_retries;
        w_loss_next    = r_loss;

        if (bus.restart) begin
            w_state_next   = S_RESET_PLL;
            w_retries_next = '0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_timer == RST_LAST) begin
                        w_state_next = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still counts as a lock.
                    if (w_locked_s) begin
                        w_state_next = S_STABLE;
                    end else if (r_timer == TIMEOUT_LAST) begin
                        w_retries_next = w_retries_inc;
                        w_state_next   = (w_retries_inc == RET_MAX) ? S_FAULT : S_RESET_PLL;
                    end
                end
                S_STABLE: begin
                    // A glitch only restarts the wait; it does not cost a retry.
                    if (!w_locked_s) begin
                        w_state_next = S_WAIT_LOCK;
                    end else if (r_timer == STABLE_LAST) begin
                        w_state_next   = S_RUN;
                        w_retries_next = '0;
                    end
                end
                S_RUN: begin
                    if (!w_locked_s) begin
                        w_state_next = S_RESET_PLL;
                        w_loss_next  = sat_inc(r_loss);
                    end
                end
                S_FAULT: begin
                end
                default: begin
                    w_state_next = S_RESET_PLL;
                end
            endcase
        end

        // restart in RESET_PLL keeps the state but must still restart the pulse.
        if ((w_state_next != r_state) || bus.restart) begin
            w_timer_next = '0;
        end
    end

    // Outputs decode the next state so they are valid in a state's first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RESET_PLL;
            r_timer     <= '0;
            r_retries   <= '0;
            r_loss      <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_lock_ok   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_retries   <= w_retries_next;
            r_loss      <= w_loss_next;
            r_pll_rst   <= (w_state_next == S_RESET_PLL) || (w_state_next == S_FAULT);
            r_sys_rst_n <= (w_state_next == S_RUN);
            r_lock_ok   <= (w_state_next == S_RUN);
            r_fault     <= (w_state_next == S_FAULT);
        end
    end

    assign bus.pll_rst    = r_pll_rst;
    assign bus.sys_rst_n  = r_sys_rst_n;
    assign bus.lock_ok    = r_lock_ok;
    assign bus.fault      = r_fault;
    assign bus.loss_count = r_loss;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//   Self-checking bench for pll_lock_supervisor with short timing parameters.
//   A behavioural model tracks which phase the supervisor must be in and for
//   how long; a compare process checks every output on every cycle, and
//   directed scenarios pin exact cycle timings with literal expectations.
// ----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int RSTC = 4;
    localparam int TO   = 32;
    localparam int STB  = 8;
    localparam int MAXR = 3;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FLT  = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pll_sup_if bus();

    pll_lock_supervisor #(
        .RST_CYCLES    (RSTC),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STB),
        .MAX_RETRIES   (MAXR),
        .CNT_W         (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    int       m_ph     = P_RST;
    int       m_el     = 0;   // cycles spent in the current phase
    int       m_tries  = 0;
    int       m_losses = 0;
    bit [1:0] m_hist   = 2'b00; // pll_locked samples from the last two edges
    bit       m_seen;
    int       m_nph;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = P_RST; m_el = 0; m_tries = 0; m_losses = 0; m_hist = 2'b00;
        end else begin
            m_seen = m_hist[1];                 // what the supervisor may act on now
            m_hist = {m_hist[0], bus.pll_locked};
            if (bus.restart) begin
                m_ph = P_RST; m_el = 0; m_tries = 0;
            end else begin
                m_nph = m_ph;
                case (m_ph)
                    P_RST:  if (m_el >= RSTC - 1) m_nph = P_WAIT;
                    P_WAIT: if (m_seen) m_nph = P_STAB;
                            else if (m_el >= TO - 1) begin
                                m_tries = m_tries + 1;
                                m_nph = (m_tries >= MAXR) ? P_FLT : P_RST;
                            end
                    P_STAB: if (!m_seen) m_nph = P_WAIT;
                            else if (m_el >= STB - 1) begin
                                m_nph = P_RUN; m_tries = 0;
                            end
                    P_RUN:  if (!m_seen) begin
                                m_nph = P_RST;
                                if (m_losses < 255) m_losses = m_losses + 1;
                            end
                    default: ;
                endcase
                if (m_nph != m_ph) begin m_ph = m_nph; m_el = 0; end
                else m_el = m_el + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            bit e_rst, e_sys, e_ok, e_flt;
            e_rst = (m_ph == P_RST) || (m_ph == P_FLT);
            e_sys = (m_ph == P_RUN);
            e_ok  = (m_ph == P_RUN);
            e_flt = (m_ph == P_FLT);
            total++;
            if (bus.pll_rst !== e_rst || bus.sys_rst_n !== e_sys || bus.lock_ok !== e_ok ||
                bus.fault !== e_flt || int'(bus.loss_count) != m_losses) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got/expected pll_rst %b/%b sys_rst_n %b/%b lock_ok %b/%b fault %b/%b loss %0d/%0d",
                         $time, bus.pll_rst, e_rst, bus.sys_rst_n, e_sys, bus.lock_ok, e_ok,
                         bus.fault, e_flt, bus.loss_count, m_losses);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("check %s ok (%0d)", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"},   int'(bus.pll_rst),    1);
        chk({tag, "_sys_rst_n"}, int'(bus.sys_rst_n),  0);
        chk({tag, "_lock_ok"},   int'(bus.lock_ok),    0);
        chk({tag, "_fault"},     int'(bus.fault),      0);
        chk({tag, "_loss"},      int'(bus.loss_count), 0);
    endtask

    int hi;
    int mode;

    initial begin
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        step(3);
        chk_reset_vals("por");

        // ---- 1: nominal lock; cycle 0 is the period right after release ----
        rst_n = 1'b1;
        chk("t1_c0_pll_rst", int'(bus.pll_rst), 1);
        step(3);  chk("t1_c3_pll_rst", int'(bus.pll_rst), 1);
        step(1);  chk("t1_c4_pll_rst", int'(bus.pll_rst), 0);
        step(5);  bus.pll_locked = 1'b1;             // first sampled at edge 10
        step(10); chk("t1_c19_sys_rst_n", int'(bus.sys_rst_n), 0);
        step(1);  chk("t1_c20_sys_rst_n", int'(bus.sys_rst_n), 1);
        chk("t1_c20_lock_ok", int'(bus.lock_ok), 1);
        chk("t1_model_run", m_ph, P_RUN);

        // ---- 4a: first lock loss in RUN ----
        step(5);
        bus.pll_locked = 1'b0; step(1);
        bus.pll_locked = 1'b1; step(2);
        chk("t4_sys_rst_n", int'(bus.sys_rst_n), 0);
        chk("t4_lock_ok",   int'(bus.lock_ok),   0);
        chk("t4_loss",      int'(bus.loss_count), 1);
        chk("t4_model_loss", m_losses, 1);
        step(3);  chk("t4_pulse_end", int'(bus.pll_rst), 1);
        step(1);  chk("t4_pulse_off", int'(bus.pll_rst), 0);
        step(10); chk("t4_relock", int'(bus.lock_ok), 1);

        // ---- 2: one-cycle glitch five cycles into STABLE ----
        bus.restart = 1'b1; step(1); bus.restart = 1'b0;
        step(3); chk("t2_c4_pll_rst", int'(bus.pll_rst), 1);
        hi = 0;
        for (int k = 5; k <= 21; k++) begin
            step(1);
            if (k == 9)  bus.pll_locked = 1'b0;
            if (k == 10) bus.pll_locked = 1'b1;
            hi += int'(bus.pll_rst);
            if (k == 20) chk("t2_c20_sys_rst_n", int'(bus.sys_rst_n), 0);
            if (k == 21) chk("t2_c21_sys_rst_n", int'(bus.sys_rst_n), 1);
        end
        chk("t2_no_pll_rst", hi, 0);

        // ---- 3: never lock -> three pulses then FAULT ----
        bus.pll_locked = 1'b0;
        bus.restart = 1'b1; step(1); bus.restart = 1'b0;
        hi = int'(bus.pll_rst);
        for (int k = 2; k <= 108; k++) begin
            step(1);
            hi += int'(bus.pll_rst);
        end
        chk("t3_pulse_cycles", hi, 3 * RSTC);
        chk("t3_c108_fault", int'(bus.fault), 0);
        step(1);
        chk("t3_fault",   int'(bus.fault),     1);
        chk("t3_pll_rst", int'(bus.pll_rst),   1);
        chk("t3_sys",     int'(bus.sys_rst_n), 0);
        step(20);
        chk("t3_fault_held", int'(bus.fault), 1);

        // ---- 5: restart out of FAULT ----
        bus.pll_locked = 1'b1;
        bus.restart = 1'b1; step(1); bus.restart = 1'b0;
        chk("t5_fault_clr", int'(bus.fault),   0);
        chk("t5_pll_rst",   int'(bus.pll_rst), 1);
        step(3); chk("t5_c4_pll_rst", int'(bus.pll_rst), 1);
        step(1); chk("t5_c5_pll_rst", int'(bus.pll_rst), 0);
        step(8); chk("t5_c13_sys", int'(bus.sys_rst_n), 0);
        step(1); chk("t5_c14_sys", int'(bus.sys_rst_n), 1);
        chk("t5_loss_kept", int'(bus.loss_count), 1);

        // ---- 4b: many losses, counter saturates ----
        for (int i = 0; i < 260; i++) begin
            bus.pll_locked = 1'b0; step(1);
            bus.pll_locked = 1'b1; step(19);
            if (i == 252) chk("t4_loss_254", int'(bus.loss_count), 254);
        end
        chk("t4_loss_sat", int'(bus.loss_count), 255);

        // ---- randomized segments ----
        for (int s = 0; s < 30; s++) begin
            mode = int'($urandom_range(0, 3));
            for (int c = 0; c < 150; c++) begin
                bus.restart = ($urandom_range(0, 199) == 0);
                case (mode)
                    0: bus.pll_locked = ($urandom_range(0, 59) != 0);
                    1: bus.pll_locked = 1'b0;
                    2: bus.pll_locked = 1'($urandom_range(0, 1));
                    default: bus.pll_locked = ($urandom_range(0, 7) != 0);
                endcase
                step(1);
            end
        end
        bus.restart = 1'b0;

        // ---- 6: async reset mid-RUN ----
        bus.pll_locked = 1'b1;
        bus.restart = 1'b1; step(1); bus.restart = 1'b0;
        step(20);
        chk("t6_in_run", int'(bus.lock_ok), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("t6");
        step(2);
        rst_n = 1'b1;
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
